// File: rtl/pixel_fetch_pkg.sv
// Shared constants and the FSM state type for the network-side pixel buffer reader.
package pixel_fetch_pkg;

   localparam int NUM_BYTES_DEF  = 72;
   localparam int NUM_PASSES_DEF = 16;
   localparam int BYTE_CNT_W     = $clog2(NUM_BYTES_DEF);
   localparam int PAIR_IDX_W     = $clog2(NUM_BYTES_DEF / 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_SHIFT_A,
      ST_SHIFT_B,
      ST_PASS_END,
      ST_REALIGN
   } state_t;

endpackage

// File: rtl/pixel_byte_cnt.sv
// Mod-NUM_BYTES byte position counter; wrap flags the shift that restores buffer alignment.
module pixel_byte_cnt
   import pixel_fetch_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DEF,
   parameter int W         = BYTE_CNT_W
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = en && (cnt == W'(NUM_BYTES - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Walks the recirculating pixel buffer pair by pair, NUM_PASSES times per start, and always
// leaves the buffer realigned (shift count a multiple of NUM_BYTES) when returning to idle.
module pixel_fetch_ctrl
   import pixel_fetch_pkg::*;
#(
   parameter  int NUM_BYTES  = NUM_BYTES_DEF,
   parameter  int NUM_PASSES = NUM_PASSES_DEF,
   localparam int CNT_W      = $clog2(NUM_BYTES),
   localparam int PAIR_W     = $clog2(NUM_BYTES / 2),
   localparam int PASS_W     = $clog2(NUM_PASSES)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              load_busy,
   input  logic              abort,
   input  logic [7:0]        pixel_data_1,
   input  logic [7:0]        pixel_data_2,
   input  logic              pair_ready,
   output logic              shift_network,
   output logic              pair_valid,
   output logic [7:0]        pixel_even,
   output logic [7:0]        pixel_odd,
   output logic [PAIR_W-1:0] pair_index,
   output logic [PASS_W-1:0] pass_index,
   output logic              pass_done,
   output logic              all_done,
   output logic              busy,
   output state_t            fsm_state
);

   // Handshake: a pair transfers on a rising clk edge where pair_valid && pair_ready;
   // pair_valid holds with stable data until then, and abort wins over pair_ready.
   state_t           state;
   logic [CNT_W-1:0] byte_cnt;
   logic             cnt_en;
   logic             cnt_clr;
   logic             cnt_wrap;
   logic             last_pass;

   assign cnt_en    = (state == ST_SHIFT_A) || (state == ST_SHIFT_B) || (state == ST_REALIGN);
   assign cnt_clr   = (state == ST_IDLE);
   assign last_pass = (pass_index == PASS_W'(NUM_PASSES - 1));
   assign fsm_state = state;

   assign pixel_even = pair_valid ? pixel_data_2 : 8'd0;
   assign pixel_odd  = pair_valid ? pixel_data_1 : 8'd0;

   pixel_byte_cnt #(
      .NUM_BYTES (NUM_BYTES),
      .W         (CNT_W)
   ) u_byte_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .cnt   (byte_cnt),
      .wrap  (cnt_wrap)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= ST_IDLE;
         pass_index    <= '0;
         pair_index    <= '0;
         pair_valid    <= 1'b0;
         shift_network <= 1'b0;
         pass_done     <= 1'b0;
         all_done      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         pass_done <= 1'b0;
         all_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !load_busy) begin
                  state      <= ST_PRESENT;
                  pass_index <= '0;
                  pair_index <= '0;
                  pair_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_PRESENT: begin
               if (abort) begin
                  pair_valid <= 1'b0;
                  if (byte_cnt == '0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state         <= ST_REALIGN;
                     shift_network <= 1'b1;
                  end
               end else if (pair_ready) begin
                  state         <= ST_SHIFT_A;
                  pair_valid    <= 1'b0;
                  shift_network <= 1'b1;
               end
            end
            ST_SHIFT_A: begin
               state <= abort ? ST_REALIGN : ST_SHIFT_B;
            end
            ST_SHIFT_B: begin
               if (cnt_wrap) begin
                  shift_network <= 1'b0;
                  // An abort on the wrapping shift is already aligned, so realigning is skipped.
                  if (abort) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state     <= ST_PASS_END;
                     pass_done <= 1'b1;
                     all_done  <= last_pass;
                  end
               end else if (abort) begin
                  state <= ST_REALIGN;
               end else begin
                  state         <= ST_PRESENT;
                  shift_network <= 1'b0;
                  pair_valid    <= 1'b1;
                  pair_index    <= pair_index + 1'b1;
               end
            end
            ST_PASS_END: begin
               if (abort || last_pass) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state      <= ST_PRESENT;
                  pass_index <= pass_index + 1'b1;
                  pair_index <= '0;
                  pair_valid <= 1'b1;
               end
            end
            ST_REALIGN: begin
               if (cnt_wrap) begin
                  state         <= ST_IDLE;
                  shift_network <= 1'b0;
                  busy          <= 1'b0;
               end
            end
            default: begin
               state         <= ST_IDLE;
               pair_valid    <= 1'b0;
               shift_network <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pixel_fetch_ctrl.md
Name: pixel_fetch_ctrl

Overview:
Network-side reader for the 72-byte recirculating pixel buffer loaded over SPI. After an image is loaded, it walks the buffer two bytes at a time and presents each pixel pair to the neural-network datapath over a valid/ready handshake. It drives the buffer's shift_network strobe, and each pass leaves the buffer back in its original alignment. It repeats the walk NUM_PASSES times, one pass per hidden neuron.

Parameters:
NUM_BYTES, 72, buffer depth in bytes; must be even.
NUM_PASSES, 16, number of full buffer walks per start.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  begin a session; level-sampled in IDLE only
load_busy  in  1  SPI load in progress; start is ignored while high
abort  in  1  cancel the session; buffer is realigned before going idle
pixel_data_1  in  8  buffer byte NUM_BYTES-2
pixel_data_2  in  8  buffer byte NUM_BYTES-1 (tail)
pair_ready  in  1  network accepts the current pair
shift_network  out  1  one-byte recirculating shift of the buffer
pair_valid  out  1  pixel pair is presented
pixel_even  out  8  image byte 2k
pixel_odd  out  8  image byte 2k+1
pair_index  out  $clog2(NUM_BYTES/2)  k, the index of the current pair
pass_index  out  $clog2(NUM_PASSES)  current pass
pass_done  out  1  one-cycle pulse at the end of each pass
all_done  out  1  one-cycle pulse at the end of the last pass
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, n_rst=0): state IDLE, byte_cnt=0, pass=0, all outputs 0. Buffer contents are not reset; alignment is lost and the top level must reload over SPI.
- Buffer model: the image byte written first sits at the tail. pixel_even = pixel_data_2 and pixel_odd = pixel_data_1 (pass-through, forced to 0 when pair_valid=0). Two shifts advance one pair. NUM_BYTES shifts restore the original alignment.
- States: IDLE, PRESENT, SHIFT_A, SHIFT_B, PASS_END, REALIGN.
- IDLE: start && !load_busy -> PRESENT; clear byte_cnt and pass.
- PRESENT: pair_valid=1; pair_index=byte_cnt/2. Transfer occurs when pair_valid && pair_ready at the clock edge -> SHIFT_A. If pair_ready stays low, hold: outputs stable, no shift.
- SHIFT_A: shift_network=1; byte_cnt+1 -> SHIFT_B.
- SHIFT_B: shift_network=1; byte_cnt+1. If byte_cnt was NUM_BYTES-1, wrap to 0 -> PASS_END; otherwise -> PRESENT.
- PASS_END: pass_done=1. On the last pass, all_done=1 too -> IDLE. Otherwise pass+1 -> PRESENT.
- Throughput: at most one pair per 3 cycles. With pair_ready held high, a pass takes 3*NUM_BYTES/2+1 = 109 cycles.
- shift_network is never asserted in IDLE, PRESENT or PASS_END.
- Abort (priority over pair_ready; no transfer in the same cycle):
  - In PRESENT with byte_cnt=0, or in PASS_END: -> IDLE. PASS_END still emits its pulses that cycle.
  - In SHIFT_A or SHIFT_B: that cycle's shift still occurs, then -> REALIGN.
  - In PRESENT with byte_cnt!=0: -> REALIGN.
- REALIGN: shift_network=1 every cycle, byte_cnt+1, until byte_cnt wraps to 0, then -> IDLE. abort and start are ignored. No pass_done or all_done.
- Invariant: total shifts per session ≡ 0 mod NUM_BYTES whenever IDLE is re-entered.
- start while busy: ignored.

Decomposition:
- Package pixel_fetch_pkg holds the NUM_BYTES default, the counter width constants and the state_t enum typedef.
- One sub-module, pixel_byte_cnt: mod-NUM_BYTES up-counter with enable, sync clear and rollover flag. It serves SHIFT_A, SHIFT_B and REALIGN.

Test Plan:
(All scenarios use a behavioural buffer model with image byte i = i, and NUM_PASSES=2.)
1. Assert n_rst=0 mid-PRESENT at pair 5 -> all outputs 0 immediately; busy=0; after release, state is IDLE and pair_valid stays 0.
2. start with pair_ready held high -> pairs (0,1),(2,3)…(70,71), pair_index 0..35. Exactly 72 shift pulses per pass. pass_done at cycles 109 and 218 after start; all_done coincides with the second pass_done. The second pass repeats the same byte values.
3. Hold pair_ready low 5 cycles on pair 3 -> pair_valid=1, pixel_even=6 and pixel_odd=7 held stable, no shift_network; the transfer happens on the first ready cycle.
4. Raise abort in SHIFT_B of pair 10 -> REALIGN brings the session total to 72 shifts, then IDLE, with no all_done. A restart then presents pair 0 = (0,1).
5. start with load_busy=1 -> stays IDLE, busy=0. Also, start pulsed mid-session -> no effect on the sequence.
6. Raise abort in PRESENT at pair 0 of pass 0 -> IDLE next cycle with zero shift pulses; pass_done and all_done stay low.
